// File: rtl/operand_sequencer.sv
// Five-word frame buffer: loads operands over valid/ready, then replays them with a 5:1 select index.
// Optional OPSEQ_FRAME_CNT_EN adds a wrapping count of completed frames (frame_cnt).
module operand_sequencer #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_sel,
  output logic [N-1:0]     out_data,
  output logic             out_last,
`ifdef OPSEQ_FRAME_CNT_EN
  output logic [CNT_W-1:0] frame_cnt,
`endif
  output logic             busy
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]   state;
  logic [2:0]   wr_idx, rd_idx;
  logic [N-1:0] opbuf [0:4];
  logic         in_acc, out_acc;

  // Handshakes are gated by rst so nothing is offered while the block is held in reset.
  assign in_ready  = ~rst & (state == LOAD);
  assign out_valid = ~rst & (state == EMIT);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  assign out_sel   = out_valid ? rd_idx : 3'd0;
  assign out_data  = out_valid ? opbuf[rd_idx] : '0;
  assign out_last  = out_valid & (rd_idx == 3'd4);
  assign busy      = ~rst & ((state == EMIT) | (wr_idx != 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      wr_idx <= 3'd0;
      rd_idx <= 3'd0;
      for (int i = 0; i < 5; i++) opbuf[i] <= '0;
    end else begin
      if (in_acc) begin
        opbuf[wr_idx] <= in_data;
        if (wr_idx == 3'd4) begin
          wr_idx <= 3'd0;
          state  <= EMIT;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end
      if (out_acc) begin
        if (rd_idx == 3'd4) begin
          rd_idx <= 3'd0;
          state  <= LOAD;
        end else begin
          rd_idx <= rd_idx + 3'd1;
        end
      end
    end
  end

`ifdef OPSEQ_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                  frame_cnt <= '0;
    else if (out_acc && out_last) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: accepted words are queued, emitted words popped and compared.
module tb_operand_sequencer;
  localparam int N     = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [2:0]       out_sel;
  logic [N-1:0]     out_data;
  logic             out_last;
  logic             busy;
`ifdef OPSEQ_FRAME_CNT_EN
  logic [CNT_W-1:0] frame_cnt;
`endif

  operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_data(out_data), .out_last(out_last),
`ifdef OPSEQ_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced at each negedge to predict the following posedge.
  logic [N-1:0]     q[$];
  logic [2:0]       m_wr = 3'd0, m_rd = 3'd0;
  logic             m_emit = 1'b0;
  logic [CNT_W-1:0] m_fc = '0;
  int               last_seen = 0;

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  !rst && !m_emit);
    chk("out_valid", out_valid, !rst && m_emit);
    chk("busy",      busy,      !rst && (m_emit || m_wr != 3'd0));
`ifdef OPSEQ_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, m_fc);
`endif
    if (!rst && m_emit) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else               chk("out_data", out_data, q[0]);
      chk("out_sel",  out_sel,  m_rd);
      chk("out_last", out_last, m_rd == 3'd4);
    end else begin
      chk("idle_data", out_data, 0);
      chk("idle_sel",  out_sel,  0);
      chk("idle_last", out_last, 0);
    end
    if (out_valid && out_ready && out_last) last_seen++;

    if (rst) begin
      q.delete();
      m_wr = 3'd0; m_rd = 3'd0; m_emit = 1'b0; m_fc = '0;
    end else if (!m_emit && in_valid) begin
      q.push_back(in_data);
      if (m_wr == 3'd4) begin m_wr = 3'd0; m_emit = 1'b1; end
      else m_wr = m_wr + 3'd1;
    end else if (m_emit && out_ready) begin
      void'(q.pop_front());
      if (m_rd == 3'd4) begin m_rd = 3'd0; m_emit = 1'b0; m_fc = m_fc + 1'b1; end
      else m_rd = m_rd + 3'd1;
    end
  end

  task automatic send_word(input logic [N-1:0] d, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_sel(input logic [2:0] s);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && out_sel == s) return;
    end
    chk("sel_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && !busy) begin @(posedge clk); #1; return; end
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back frame
    for (int i = 1; i <= 5; i++) send_word(N'(i * 'h11), 0);
    wait_idle();

    // Gapped load, then a 3-cycle stall at sel 2
    for (int i = 0; i < 5; i++) send_word(N'('h100 + i), i % 3);
    wait_sel(3'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sel",  out_sel,  3'd2);
      chk("stall_data", out_data, 'h102);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // Upstream holds 0xDEAD through EMIT; it lands as word 0 of the next frame
    for (int i = 0; i < 5; i++) send_word(N'('h200 + i), 0);
    send_word(N'('hDEAD), 0);
    for (int i = 1; i < 5; i++) send_word(N'('h300 + i), 0);
    wait_idle();

    // Reset after a partial load
    for (int i = 0; i < 3; i++) send_word(N'('hBAD0 + i), 0);
    pulse_rst();
    @(negedge clk);
    chk("busy_after_rst", busy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_word(N'('hA0 + i), 0);
    wait_idle();

    // Reset during EMIT at sel 3
    for (int i = 0; i < 5; i++) send_word(N'('h400 + i), 0);
    wait_sel(3'd2);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", out_sel, 3'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_word(N'($urandom), $urandom_range(0, 2));
    wait_idle();

    chk("frames_emitted", last_seen, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
